// File: rtl/histogram_median_reader_if.sv
// Histogram block <-> median reader link: read/clear requests and per-axis bin streams.
// master = median reader side, slave = histogram block side.
interface histogram_median_reader_if;
    logic       read_hist;
    logic       clear_hist;
    logic       hist_clear;
    logic [7:0] x_bin;
    logic       x_valid;
    logic [7:0] y_bin;
    logic       y_valid;

    modport master (
        output read_hist, clear_hist,
        input  hist_clear, x_bin, x_valid, y_bin, y_valid
    );

    modport slave (
        input  read_hist, clear_hist,
        output hist_clear, x_bin, x_valid, y_bin, y_valid
    );
endinterface

// File: rtl/histogram_median_reader.sv
// Drives two histogram read-out passes (totals, then median search), clears the histogram,
// and strobes the X/Y median result. All outputs registered; sync active-high reset.
module histogram_median_reader #(
    parameter int X_BINS         = 240,
    parameter int Y_BINS         = 180,
    parameter int GAP_CYCLES     = 4,
    parameter int MIN_CLEAR_WAIT = 260,
    parameter int TIMEOUT        = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    histogram_median_reader_if.master        hist,
    output logic [7:0]                       x_median,
    output logic [7:0]                       y_median,
    output logic [15:0]                      x_total,
    output logic [15:0]                      y_total,
    output logic                             result_valid,
    output logic                             empty,
    output logic                             error
);
    localparam int TW = $clog2(TIMEOUT + MIN_CLEAR_WAIT + GAP_CYCLES + 2);
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);
    localparam logic [TW-1:0] CLR_MIN  = TW'(MIN_CLEAR_WAIT);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [7:0]    X_LAST   = 8'(X_BINS - 1);
    localparam logic [7:0]    Y_LAST   = 8'(Y_BINS - 1);

    typedef enum logic [3:0] {
        IDLE, REQ1, PASS1, GAP1, REQ2, PASS2, GAP2, CLRREQ, CLRWAIT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    x_idx_q, x_idx_d, y_idx_q, y_idx_d;
    logic [15:0]   x_cum_q, x_cum_d, y_cum_q, y_cum_d;
    logic [15:0]   x_total_q, x_total_d, y_total_q, y_total_d;
    logic [7:0]    x_median_q, x_median_d, y_median_q, y_median_d;
    logic          x_seen_q, x_seen_d, y_seen_q, y_seen_d;
    logic          x_done_q, x_done_d, y_done_q, y_done_d;
    logic          x_found_q, x_found_d, y_found_q, y_found_d;
    logic          busy_q, busy_d, read_hist_q, read_hist_d, clear_hist_q, clear_hist_d;
    logic          result_valid_q, result_valid_d, empty_q, empty_d, error_q, error_d;

    logic [16:0]   x_cum_nxt, y_cum_nxt;
    logic          x_take, y_take, x_fall, y_fall;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] last);
        return (v == last) ? v : v + 8'd1;
    endfunction

    // Median is the first bin where the running sum reaches half the total.
    function automatic logic median_hit(input logic [16:0] cum, input logic [15:0] tot);
        return (tot != 16'd0) && ({cum, 1'b0} >= {2'b00, tot});
    endfunction

    assign x_cum_nxt = {1'b0, x_cum_q} + {9'd0, hist.x_bin};
    assign y_cum_nxt = {1'b0, y_cum_q} + {9'd0, hist.y_bin};
    assign x_take    = hist.x_valid & ~x_done_q;
    assign y_take    = hist.y_valid & ~y_done_q;
    assign x_fall    = x_seen_q & ~hist.x_valid;
    assign y_fall    = y_seen_q & ~hist.y_valid;

    always_comb begin
        state_d    = state_q;
        x_idx_d    = x_idx_q;    y_idx_d    = y_idx_q;
        x_cum_d    = x_cum_q;    y_cum_d    = y_cum_q;
        x_total_d  = x_total_q;  y_total_d  = y_total_q;
        x_median_d = x_median_q; y_median_d = y_median_q;
        x_seen_d   = x_seen_q;   y_seen_d   = y_seen_q;
        x_done_d   = x_done_q;   y_done_d   = y_done_q;
        x_found_d  = x_found_q;  y_found_d  = y_found_q;
        empty_d    = empty_q;    error_d    = error_q;

        case (state_q)
            IDLE: if (start) begin
                x_idx_d = '0; y_idx_d = '0; x_cum_d = '0; y_cum_d = '0;
                x_total_d = '0; y_total_d = '0; x_median_d = '0; y_median_d = '0;
                x_seen_d = 1'b0; y_seen_d = 1'b0; x_done_d = 1'b0; y_done_d = 1'b0;
                x_found_d = 1'b0; y_found_d = 1'b0; empty_d = 1'b0; error_d = 1'b0;
                state_d = REQ1;
            end
            REQ1: state_d = PASS1;
            REQ2: state_d = PASS2;
            PASS1, PASS2: begin
                if (x_take) begin
                    x_seen_d = 1'b1;
                    x_idx_d  = sat_inc(x_idx_q, X_LAST);
                    if (state_q == PASS1) begin
                        x_total_d = x_total_q + {8'd0, hist.x_bin};
                    end else begin
                        x_cum_d = x_cum_nxt[15:0];
                        if (!x_found_q && median_hit(x_cum_nxt, x_total_q)) begin
                            x_median_d = x_idx_q;
                            x_found_d  = 1'b1;
                        end
                    end
                end
                if (y_take) begin
                    y_seen_d = 1'b1;
                    y_idx_d  = sat_inc(y_idx_q, Y_LAST);
                    if (state_q == PASS1) begin
                        y_total_d = y_total_q + {8'd0, hist.y_bin};
                    end else begin
                        y_cum_d = y_cum_nxt[15:0];
                        if (!y_found_q && median_hit(y_cum_nxt, y_total_q)) begin
                            y_median_d = y_idx_q;
                            y_found_d  = 1'b1;
                        end
                    end
                end
                if (x_fall) x_done_d = 1'b1;
                if (y_fall) y_done_d = 1'b1;
                if (x_done_d && y_done_d) begin
                    state_d = (state_q == PASS1) ? GAP1 : GAP2;
                end else if (timer_q > TO_LIM) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            GAP1, GAP2: begin
                x_idx_d = '0; y_idx_d = '0; x_cum_d = '0; y_cum_d = '0;
                x_seen_d = 1'b0; y_seen_d = 1'b0; x_done_d = 1'b0; y_done_d = 1'b0;
                if (timer_q == GAP_LAST) state_d = (state_q == GAP1) ? REQ2 : CLRREQ;
            end
            CLRREQ: state_d = CLRWAIT;
            // A clear-done level left over from an earlier clear must not end the wait early.
            CLRWAIT: begin
                if (timer_q >= CLR_MIN && hist.hist_clear) begin
                    state_d = DONE;
                end else if (timer_q > TO_LIM) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + 1'b1;

        if (state_d == DONE) begin
            empty_d = (x_total_d == 16'd0) || (y_total_d == 16'd0);
            if (empty_d) begin
                x_median_d = '0;
                y_median_d = '0;
            end
        end

        read_hist_d    = (state_d == REQ1) || (state_d == REQ2);
        clear_hist_d   = (state_d == CLRREQ);
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;       timer_q <= '0;
            x_idx_q <= '0;         y_idx_q <= '0;
            x_cum_q <= '0;         y_cum_q <= '0;
            x_total_q <= '0;       y_total_q <= '0;
            x_median_q <= '0;      y_median_q <= '0;
            x_seen_q <= 1'b0;      y_seen_q <= 1'b0;
            x_done_q <= 1'b0;      y_done_q <= 1'b0;
            x_found_q <= 1'b0;     y_found_q <= 1'b0;
            busy_q <= 1'b0;        read_hist_q <= 1'b0;
            clear_hist_q <= 1'b0;  result_valid_q <= 1'b0;
            empty_q <= 1'b0;       error_q <= 1'b0;
        end else begin
            state_q <= state_d;           timer_q <= timer_d;
            x_idx_q <= x_idx_d;           y_idx_q <= y_idx_d;
            x_cum_q <= x_cum_d;           y_cum_q <= y_cum_d;
            x_total_q <= x_total_d;       y_total_q <= y_total_d;
            x_median_q <= x_median_d;     y_median_q <= y_median_d;
            x_seen_q <= x_seen_d;         y_seen_q <= y_seen_d;
            x_done_q <= x_done_d;         y_done_q <= y_done_d;
            x_found_q <= x_found_d;       y_found_q <= y_found_d;
            busy_q <= busy_d;             read_hist_q <= read_hist_d;
            clear_hist_q <= clear_hist_d; result_valid_q <= result_valid_d;
            empty_q <= empty_d;           error_q <= error_d;
        end
    end

    assign busy            = busy_q;
    assign hist.read_hist  = read_hist_q;
    assign hist.clear_hist = clear_hist_q;
    assign x_median        = x_median_q;
    assign y_median        = y_median_q;
    assign x_total         = x_total_q;
    assign y_total         = y_total_q;
    assign result_valid    = result_valid_q;
    assign empty           = empty_q;
    assign error           = error_q;
endmodule

// File: tb/tb_histogram_median_reader.sv
// Directed bench for histogram_median_reader: a behavioural histogram block streams
// bin tables on each read request; results are checked against hand-computed values.
module tb_histogram_median_reader;
    localparam int X_BINS = 240, Y_BINS = 180, GAP_CYCLES = 4;
    localparam int MIN_CLEAR_WAIT = 260, TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        reset, start, busy, result_valid, empty, error;
    logic [7:0]  x_median, y_median;
    logic [15:0] x_total, y_total;

    histogram_median_reader_if hif();

    histogram_median_reader #(
        .X_BINS(X_BINS), .Y_BINS(Y_BINS), .GAP_CYCLES(GAP_CYCLES),
        .MIN_CLEAR_WAIT(MIN_CLEAR_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .hist(hif),
        .x_median(x_median), .y_median(y_median), .x_total(x_total), .y_total(y_total),
        .result_valid(result_valid), .empty(empty), .error(error)
    );

    always #5 clk = ~clk;

    logic [7:0]  x_mem [0:255];
    logic [7:0]  y_mem [0:255];
    int          nx, ny;
    int          errs = 0, checks = 0;
    int          cyc = 0, rd_cnt = 0, clr_cnt = 0, rv_cnt = 0, clr_time = 0, rv_time = 0;
    logic [7:0]  got_xm, got_ym;
    logic [15:0] got_xt, got_yt;
    logic        got_empty, got_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (hif.read_hist) rd_cnt++;
        if (hif.clear_hist) begin clr_cnt++; clr_time = cyc; end
        if (result_valid) begin rv_cnt++; rv_time = cyc; end
    end

    // Histogram block model: streams both tables starting the cycle after a read request.
    initial begin
        hif.x_valid = 1'b0; hif.y_valid = 1'b0; hif.x_bin = '0; hif.y_bin = '0;
        forever begin
            @(negedge clk);
            if (hif.read_hist) begin
                for (int i = 0; i < ((nx > ny) ? nx : ny); i++) begin
                    @(negedge clk);
                    hif.x_valid = (i < nx);
                    hif.x_bin   = (i < nx) ? x_mem[i] : 8'd0;
                    hif.y_valid = (i < ny);
                    hif.y_bin   = (i < ny) ? y_mem[i] : 8'd0;
                end
                @(negedge clk);
                hif.x_valid = 1'b0; hif.y_valid = 1'b0; hif.x_bin = '0; hif.y_bin = '0;
            end
        end
    end

    task automatic load(input int n_x, input int n_y);
        for (int i = 0; i < 256; i++) begin x_mem[i] = 8'd0; y_mem[i] = 8'd0; end
        nx = n_x; ny = n_y;
    endtask

    task automatic run(input string tag, input bit extra_start);
        bit seen = 1'b0;
        rd_cnt = 0; clr_cnt = 0; rv_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_req1"}, hif.read_hist, 1);
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            start = (extra_start && k == 30);
            if (result_valid) begin
                seen = 1'b1;
                got_xm = x_median; got_ym = y_median; got_xt = x_total; got_yt = y_total;
                got_empty = empty; got_err = error;
            end
        end
        start = 1'b0;
        check({tag, "_result_seen"}, seen, 1);
        @(negedge clk);
        check({tag, "_rv_one_cycle"}, result_valid, 0);
        @(negedge clk);
        check({tag, "_busy_fall"}, busy, 0);
    endtask

    task automatic expect_res(input string tag, input int xm, input int ym, input int xt,
                              input int yt, input int emp, input int err);
        check({tag, "_x_median"}, got_xm, xm);
        check({tag, "_y_median"}, got_ym, ym);
        check({tag, "_x_total"}, got_xt, xt);
        check({tag, "_y_total"}, got_yt, yt);
        check({tag, "_empty"}, got_empty, emp);
        check({tag, "_error"}, got_err, err);
        check({tag, "_read_pulses"}, rd_cnt, 2);
        check({tag, "_clear_pulses"}, clr_cnt, 1);
        check({tag, "_result_pulses"}, rv_cnt, 1);
        check({tag, "_x_median_hold"}, x_median, xm);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; hif.hist_clear = 1'b1;
        load(240, 180);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_read", hif.read_hist, 0);
        check("rst_clear", hif.clear_hist, 0);
        check("rst_rv", result_valid, 0);
        check("rst_outs", {x_median, y_median, x_total, y_total, empty, error}, 0);
        reset = 1'b0;

        // Single spike per axis; also a start pulse mid-run that must be ignored.
        load(240, 180); x_mem[10] = 8'd4; y_mem[100] = 8'd4;
        run("spike", 1'b1);
        expect_res("spike", 10, 100, 4, 4, 0, 0);
        check("spike_clr_min", (rv_time - clr_time) >= MIN_CLEAR_WAIT, 1);
        check("spike_clr_max", (rv_time - clr_time) <= MIN_CLEAR_WAIT + 4, 1);

        load(4, 3);
        for (int i = 0; i < 4; i++) x_mem[i] = 8'd1;
        for (int i = 0; i < 3; i++) y_mem[i] = 8'd1;
        run("small", 1'b0);
        expect_res("small", 1, 1, 4, 3, 0, 0);

        load(240, 180);
        run("zero", 1'b0);
        expect_res("zero", 0, 0, 0, 0, 1, 0);

        // Full X table at 255; both streams end together.
        load(240, 240);
        for (int i = 0; i < 240; i++) begin x_mem[i] = 8'd255; y_mem[i] = 8'd1; end
        run("full", 1'b0);
        expect_res("full", 119, 119, 61200, 240, 0, 0);

        // Y index saturates at Y_BINS-1 when extra bins arrive.
        load(200, 200); x_mem[0] = 8'd1; y_mem[195] = 8'd5;
        run("sat", 1'b0);
        expect_res("sat", 0, 179, 1, 5, 0, 0);

        // Clear never completes: timeout after TIMEOUT cycles, results retained.
        hif.hist_clear = 1'b0;
        load(4, 3);
        for (int i = 0; i < 4; i++) x_mem[i] = 8'd1;
        for (int i = 0; i < 3; i++) y_mem[i] = 8'd1;
        run("tmo", 1'b0);
        expect_res("tmo", 1, 1, 4, 3, 0, 1);
        check("tmo_wait_min", (rv_time - clr_time) > TIMEOUT, 1);
        check("tmo_wait_max", (rv_time - clr_time) <= TIMEOUT + 4, 1);
        hif.hist_clear = 1'b1;

        // Reset in the middle of the second pass.
        load(240, 180); x_mem[10] = 8'd4; y_mem[100] = 8'd4;
        rv_cnt = 0; n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 3000 && n < 2; k++) begin
            if (hif.read_hist) n++;
            if (n < 2) @(negedge clk);
        end
        check("mid_second_req", n, 2);
        repeat (20) @(negedge clk);
        check("mid_total_before", x_total, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_total", x_total, 0);
        check("mid_rst_read", hif.read_hist, 0);
        @(negedge clk);
        check("mid_no_req_after", {hif.read_hist, hif.clear_hist}, 0);
        repeat (300) @(negedge clk);
        check("mid_no_result", rv_cnt, 0);
        run("rerun", 1'b0);
        expect_res("rerun", 10, 100, 4, 4, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
